// File: rtl/seg_scan_driver.sv
// Eight-digit multiplexed hex display scanner with frame-coherent snapshot,
// per-slot anode dead time and optional leading-zero blanking.
module seg_scan_driver #(
  parameter int unsigned DIV  = 50000,
  parameter int unsigned DEAD = 64
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] IOD,
  input  logic [7:0] IOE,
  input  logic [7:0] IOF,
  input  logic [7:0] IOG,
  input  logic       HOLD,
  input  logic       BLANK_LZ,
  output logic [7:0] AN,
  output logic [6:0] SEG,
  output logic       FRAME
);

  logic [15:0] pre;
  logic [2:0]  idx;
  logic [31:0] sh;

  logic        slot_end;
  logic        frame_edge;
  logic [7:0]  upper_zero;
  logic [3:0]  digit;
  logic        blanked;
  logic        dark;
  logic [6:0]  seg_dec;

  assign slot_end   = (pre == 16'(DIV - 1));
  assign frame_edge = slot_end && (idx == 3'd7);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      pre <= '0;
      idx <= '0;
      sh  <= '0;
    end else begin
      pre <= slot_end ? '0 : pre + 16'd1;
      if (slot_end)
        idx <= idx + 3'd1;
      if (frame_edge && !HOLD)
        sh <= {IOG, IOF, IOE, IOD};
    end
  end

  // upper_zero[i]: digits i..7 of the snapshot are all zero
  always_comb begin
    upper_zero    = '0;
    upper_zero[7] = (sh[31:28] == 4'h0);
    for (int unsigned k = 1; k < 8; k++)
      upper_zero[7-k] = upper_zero[8-k] && (sh[4*(7-k) +: 4] == 4'h0);
  end

  assign digit   = sh[{idx, 2'b00} +: 4];
  assign blanked = BLANK_LZ && (idx != 3'd0) && upper_zero[idx];
  assign dark    = (pre < 16'(DEAD)) || blanked;

  always_comb begin
    seg_dec = 7'h7F;
    case (digit)
      4'h0: seg_dec = 7'h40;
      4'h1: seg_dec = 7'h79;
      4'h2: seg_dec = 7'h24;
      4'h3: seg_dec = 7'h30;
      4'h4: seg_dec = 7'h19;
      4'h5: seg_dec = 7'h12;
      4'h6: seg_dec = 7'h02;
      4'h7: seg_dec = 7'h78;
      4'h8: seg_dec = 7'h00;
      4'h9: seg_dec = 7'h10;
      4'hA: seg_dec = 7'h08;
      4'hB: seg_dec = 7'h03;
      4'hC: seg_dec = 7'h46;
      4'hD: seg_dec = 7'h21;
      4'hE: seg_dec = 7'h06;
      4'hF: seg_dec = 7'h0E;
      default: seg_dec = 7'h7F;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      AN    <= '1;
      SEG   <= '1;
      FRAME <= 1'b0;
    end else begin
      AN    <= dark ? '1 : ~(8'b1 << idx);
      SEG   <= dark ? '1 : seg_dec;
      FRAME <= frame_edge;
    end
  end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter DIV, default 50000: clock cycles per digit slot; legal range 2..65535.
REQ-002 SHALL have parameter DEAD, default 64: anode-off cycles at the start of each slot; legal range 0..DIV-1.
REQ-003 SHALL have port CLK, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port RESET, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port IOD, input, 8: display byte 0, digits 1:0.
REQ-006 SHALL have port IOE, input, 8: display byte 1, digits 3:2.
REQ-007 SHALL have port IOF, input, 8: display byte 2, digits 5:4.
REQ-008 SHALL have port IOG, input, 8: display byte 3, digits 7:6.
REQ-009 SHALL have port HOLD, input, 1: when high, freezes the displayed snapshot.
REQ-010 SHALL have port BLANK_LZ, input, 1: when high, enables leading-zero blanking.
REQ-011 SHALL have port AN, output, 8: active-low digit enables; AN[i] selects digit i.
REQ-012 SHALL have port SEG, output, 7: active-low cathodes {g,f,e,d,c,b,a}.
REQ-013 SHALL have port FRAME, output, 1: one-cycle pulse on each snapshot boundary.

Function
REQ-014 SHALL contain a prescaler PRE counting 0..DIV-1 and wrapping to 0.
REQ-015 SHALL contain a 3-bit digit index IDX that advances by 1 (mod 8, 7->0) on the edge where PRE==DIV-1.
REQ-016 SHALL contain a 32-bit shadow register SH = {IOG,IOF,IOE,IOD}, loaded only on the frame edge (IDX==7 and PRE==DIV-1) with HOLD low.
REQ-017 SHALL hold SH unchanged on a frame edge with HOLD high; HOLD sampled only at frame edges.
REQ-018 SHALL map digit i to SH[4i+3:4i] (digit 0 = IOD[3:0], digit 7 = IOG[7:4]).
REQ-019 SHALL treat digit i as blanked when BLANK_LZ=1, i>0, and SH[31:4i]==0; digit 0 SHALL never be blanked.
REQ-020 SHALL register AN, SEG and FRAME, each a function of pre-edge PRE/IDX/SH/BLANK_LZ; outputs lag the internal counters by one cycle.
REQ-021 SHALL drive AN=8'hFF and SEG=7'h7F when PRE<DEAD or the current digit is blanked.
REQ-022 SHALL otherwise drive AN = ~(1<<IDX) and SEG = hex decode of digit IDX.
REQ-023 SHALL use hex decode 0=40,1=79,2=24,3=30,4=19,5=12,6=02,7=78,8=00,9=10,A=08,b=03,C=46,d=21,E=06,F=0E (hex, 7-bit).
REQ-024 SHALL assert FRAME for exactly one cycle, the cycle after each frame edge, regardless of HOLD.
REQ-025 SHALL never assert more than one AN bit low in any cycle.
REQ-026 SHALL ignore IOD..IOG changes between frame edges; the display is frame-coherent.

Reset
REQ-027 SHALL, while RESET=0, force PRE=0, IDX=0, SH=0, AN=8'hFF, SEG=7'h7F, FRAME=0 immediately, independent of CLK.
REQ-028 SHALL, after RESET rises, begin counting at PRE=0/IDX=0 on the first CLK edge; digits show 0 (or blank when BLANK_LZ=1) until the first frame edge, 8*DIV cycles later.
REQ-029 SHALL, on reset asserted mid-slot or mid-frame, discard partial counts and snapshot with no glitch other than AN going to 8'hFF.

Verification (DIV=4, DEAD=1)
REQ-030 SHALL verify reset: RESET low asynchronously mid-slot -> AN=FF, SEG=7F, FRAME=0 in the same cycle, before any CLK edge.
REQ-031 SHALL verify the scan sequence: IOD..IOG=12,34,56,78 held, BLANK_LZ=0 -> after the first FRAME, the slot with AN=FE shows SEG=24 ("2") and the slot with AN=7F shows SEG=78 ("7"), each lit for 3 cycles following 1 dead cycle, with a 32-cycle frame period.
REQ-032 SHALL verify coherence: change IOD to AB mid-frame -> no display change until the cycle after the next FRAME pulse, then digit 0 shows SEG=03 ("b").
REQ-033 SHALL verify HOLD: HOLD=1 across a frame edge with new inputs -> FRAME still pulses and SEG values are unchanged for the whole next frame.
REQ-034 SHALL verify blanking: IOD=05, IOE..IOG=00, BLANK_LZ=1 -> only AN=FE ever goes low, with SEG=12; the other 7 slots keep AN=FF.
REQ-035 SHALL verify one-hot AN via an assertion: AN is never driven with more than one 0 bit, across the random-input run.
